cmp_unit_pipe: RTL

- Parametrised, pipelined successor to the team's 16-bit ALU compare unit.
- Compares two operands (EQ/NE/GT/GE/LT, MIN/MAX) in unsigned or signed mode behind valid/ready handshakes, with full throughput and backpressure.
- Keeps a saturating hit counter of true comparisons for debug/statistics.
- Sits beside the ALU arithmetic/logic units; its output feeds the ALU result mux.

---
 rtl/cmp_pkg.sv | 20 ++
 rtl/cmp_core.sv | 26 ++
 rtl/cmp_unit_pipe.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/cmp_pkg.sv
// Shared definitions for the pipelined compare unit: function codes and
// the fixed result encodings of the compare operations.
package cmp_pkg;

    // ALU_FUNC encodings (001-011 match the legacy compare unit)
    localparam logic [2:0] CMP_NOP = 3'b000;
    localparam logic [2:0] CMP_EQ  = 3'b001;
    localparam logic [2:0] CMP_GT  = 3'b010;
    localparam logic [2:0] CMP_LT  = 3'b011;
    localparam logic [2:0] CMP_NE  = 3'b100;
    localparam logic [2:0] CMP_GE  = 3'b101;
    localparam logic [2:0] CMP_MAX = 3'b110;
    localparam logic [2:0] CMP_MIN = 3'b111;

    // CMP_OUT value driven when a compare condition is true
    localparam logic [1:0] RES_EQ = 2'd1;
    localparam logic [1:0] RES_GT = 2'd2;
    localparam logic [1:0] RES_LT = 2'd3;

endpackage

// File: rtl/cmp_core.sv
// Combinational magnitude comparator: equal / greater / less for two
// DATA_WIDTH operands, interpreted as unsigned or two's complement.
module cmp_core #(
    parameter int DATA_WIDTH = 16
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  signed_mode,
    output logic                  eq,
    output logic                  gt,
    output logic                  lt
);

    // Equality is sign-agnostic; ordering depends on the selected mode
    always_comb begin
        eq = (a == b);
        if (signed_mode) begin
            gt = ($signed(a) > $signed(b));
            lt = ($signed(a) < $signed(b));
        end else begin
            gt = (a > b);
            lt = (a < b);
        end
    end

endmodule

// File: rtl/cmp_unit_pipe.sv
// Two-stage pipelined compare unit with valid/ready handshakes on both
// sides, a result mux feeding the ALU result path, and a saturating
// counter of true results accepted downstream.
module cmp_unit_pipe
    import cmp_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int OUT_WIDTH  = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  IN_VALID,
    output logic                  IN_READY,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    input  logic [2:0]            ALU_FUNC,
    input  logic                  SIGNED_MODE,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY,
    output logic [OUT_WIDTH-1:0]  CMP_OUT,
    output logic                  CMP_Flag,
    input  logic                  CNT_CLR,
    output logic [CNT_WIDTH-1:0]  HIT_CNT
);

    // Extend (or truncate) a selected operand to the result width; the
    // extra MSB carries the sign only in signed mode.
    function automatic logic [OUT_WIDTH-1:0] extend_sel(
        input logic [DATA_WIDTH-1:0] v,
        input logic                  sgn
    );
        logic [DATA_WIDTH:0] wide;
        wide = {sgn & v[DATA_WIDTH-1], v};
        return OUT_WIDTH'($signed(wide));
    endfunction

    // Stage 1 state
    logic                  s1_valid_r;
    logic [DATA_WIDTH-1:0] s1_a_r;
    logic [DATA_WIDTH-1:0] s1_b_r;
    logic [2:0]            s1_func_r;
    logic                  s1_signed_r;
    logic                  s1_eq_r;
    logic                  s1_gt_r;
    logic                  s1_lt_r;

    // Stage 2 state
    logic                  out_valid_r;
    logic [OUT_WIDTH-1:0]  cmp_out_r;
    logic                  cmp_flag_r;
    logic [CNT_WIDTH-1:0]  hit_cnt_r;

    // Control and datapath nets
    logic                  adv2_s;
    logic                  accept_s;
    logic                  fire_s;
    logic                  eq_s;
    logic                  gt_s;
    logic                  lt_s;
    logic [OUT_WIDTH-1:0]  res_out_s;
    logic                  res_flag_s;

    assign adv2_s   = !out_valid_r || OUT_READY;
    assign IN_READY = !s1_valid_r || adv2_s;
    assign accept_s = IN_VALID && IN_READY;
    assign fire_s   = out_valid_r && OUT_READY;

    assign OUT_VALID = out_valid_r;
    assign CMP_OUT   = cmp_out_r;
    assign CMP_Flag  = cmp_flag_r;
    assign HIT_CNT   = hit_cnt_r;

    cmp_core #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_core (
        .a           (A),
        .b           (B),
        .signed_mode (SIGNED_MODE),
        .eq          (eq_s),
        .gt          (gt_s),
        .lt          (lt_s)
    );

    // Stage 1: capture operands and compare results on accept, drop valid
    // when the entry moves on without a replacement
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            s1_valid_r  <= 1'b0;
            s1_a_r      <= '0;
            s1_b_r      <= '0;
            s1_func_r   <= CMP_NOP;
            s1_signed_r <= 1'b0;
            s1_eq_r     <= 1'b0;
            s1_gt_r     <= 1'b0;
            s1_lt_r     <= 1'b0;
        end else if (accept_s) begin
            s1_valid_r  <= 1'b1;
            s1_a_r      <= A;
            s1_b_r      <= B;
            s1_func_r   <= ALU_FUNC;
            s1_signed_r <= SIGNED_MODE;
            s1_eq_r     <= eq_s;
            s1_gt_r     <= gt_s;
            s1_lt_r     <= lt_s;
        end else if (adv2_s) begin
            s1_valid_r  <= 1'b0;
        end
    end

    // Result mux: turn the registered compare flags into CMP_OUT/CMP_Flag
    always_comb begin
        res_out_s  = '0;
        res_flag_s = 1'b0;
        case (s1_func_r)
            CMP_NOP: begin
                res_out_s  = '0;
                res_flag_s = 1'b0;
            end
            CMP_EQ: begin
                res_flag_s = s1_eq_r;
                res_out_s  = s1_eq_r ? OUT_WIDTH'(RES_EQ) : '0;
            end
            CMP_GT: begin
                res_flag_s = s1_gt_r;
                res_out_s  = s1_gt_r ? OUT_WIDTH'(RES_GT) : '0;
            end
            CMP_LT: begin
                res_flag_s = s1_lt_r;
                res_out_s  = s1_lt_r ? OUT_WIDTH'(RES_LT) : '0;
            end
            CMP_NE: begin
                res_flag_s = !s1_eq_r;
                res_out_s  = !s1_eq_r ? OUT_WIDTH'(RES_EQ) : '0;
            end
            CMP_GE: begin
                res_flag_s = !s1_lt_r;
                res_out_s  = !s1_lt_r ? OUT_WIDTH'(RES_EQ) : '0;
            end
            CMP_MAX: begin
                // A wins ties
                res_flag_s = !s1_lt_r;
                res_out_s  = extend_sel(!s1_lt_r ? s1_a_r : s1_b_r, s1_signed_r);
            end
            CMP_MIN: begin
                // A wins ties
                res_flag_s = !s1_gt_r;
                res_out_s  = extend_sel(!s1_gt_r ? s1_a_r : s1_b_r, s1_signed_r);
            end
            default: begin
                res_out_s  = '0;
                res_flag_s = 1'b0;
            end
        endcase
    end

    // Stage 2: advance when the output slot is free or being consumed; an
    // empty stage 1 produces a zeroed bubble
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            out_valid_r <= 1'b0;
            cmp_out_r   <= '0;
            cmp_flag_r  <= 1'b0;
        end else if (adv2_s) begin
            out_valid_r <= s1_valid_r;
            cmp_out_r   <= s1_valid_r ? res_out_s : '0;
            cmp_flag_r  <= s1_valid_r ? res_flag_s : 1'b0;
        end
    end

    // Hit counter: count consumed true results, saturate, clear wins
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            hit_cnt_r <= '0;
        end else if (CNT_CLR) begin
            hit_cnt_r <= '0;
        end else if (fire_s && cmp_flag_r && !(&hit_cnt_r)) begin
            hit_cnt_r <= hit_cnt_r + CNT_WIDTH'(1);
        end
    end

endmodule
